// File: rtl/frac_clken_gen.sv
// frac_clken_gen: multi-channel fractional clock-enable generator.
// Each channel runs a phase accumulator in the refclk domain. The carry out
// of the accumulator becomes a one-cycle enable pulse, and the accumulator
// MSB becomes a square wave. Channels can be reprogrammed at runtime through
// a valid/ready config port. While outputs settle after reset or after a
// reconfiguration, `locked` is held low.
module frac_clken_gen #(
    parameter int NUM_CH = 3,
    parameter int ACC_W  = 32,
    parameter int SETTLE = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_INC = '0,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq,
    output logic              locked
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_RUN,
        ST_APPLY
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         locked_q, locked_d;
    logic                         rdy_q, rdy_d;
    logic                         err_q, err_d;
    logic [CH_W-1:0]              lat_ch_q, lat_ch_d;
    logic [ACC_W-1:0]             lat_inc_q, lat_inc_d;
    logic [ACC_W-1:0]             lat_phase_q, lat_phase_d;
    logic [NUM_CH-1:0][ACC_W-1:0] inc_q, inc_d;
    logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0]            ce_q, ce_d;
    logic [NUM_CH-1:0]            sq_q, sq_d;

    logic                         accept;
    logic                         ch_ok;
    logic                         applying;
    logic [ACC_W:0]               sum;

    // The handshake completes on any accepted request; out-of-range channels
    // are consumed and flagged instead of being applied.
    assign accept   = cfg_valid && rdy_q;
    assign ch_ok    = (32'(cfg_ch) < NUM_CH);
    assign applying = (state_q == ST_APPLY);

    // Control FSM next state: settle counter, config latch, lock/ready flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        locked_d    = locked_q;
        rdy_d       = rdy_q;
        err_d       = 1'b0;
        lat_ch_d    = lat_ch_q;
        lat_inc_d   = lat_inc_q;
        lat_phase_d = lat_phase_q;
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d  = ST_RUN;
                    locked_d = 1'b1;
                    rdy_d    = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (ch_ok) begin
                        lat_ch_d    = cfg_ch;
                        lat_inc_d   = cfg_inc;
                        lat_phase_d = cfg_phase;
                        state_d     = ST_APPLY;
                        rdy_d       = 1'b0;
                        locked_d    = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_APPLY: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-channel accumulators: advance every cycle, except the channel being
    // applied, which is loaded with the latched increment and phase.
    always_comb begin
        inc_d = inc_q;
        acc_d = acc_q;
        ce_d  = '0;
        sq_d  = sq_q;
        sum   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, acc_q[k]} + {1'b0, inc_q[k]};
            if (applying && (32'(lat_ch_q) == k)) begin
                inc_d[k] = lat_inc_q;
                acc_d[k] = lat_phase_q;
                ce_d[k]  = 1'b0;
                sq_d[k]  = lat_phase_q[ACC_W-1];
            end else begin
                acc_d[k] = sum[ACC_W-1:0];
                ce_d[k]  = sum[ACC_W];
                sq_d[k]  = sum[ACC_W-1];
            end
        end
    end

    // State registers; an asynchronous reset discards any latched config.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SETTLE;
            cnt_q       <= '0;
            locked_q    <= 1'b0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
            lat_ch_q    <= '0;
            lat_inc_q   <= '0;
            lat_phase_q <= '0;
            inc_q       <= DEF_INC;
            acc_q       <= '0;
            ce_q        <= '0;
            sq_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
            lat_ch_q    <= lat_ch_d;
            lat_inc_q   <= lat_inc_d;
            lat_phase_q <= lat_phase_d;
            inc_q       <= inc_d;
            acc_q       <= acc_d;
            ce_q        <= ce_d;
            sq_q        <= sq_d;
        end
    end

    assign cfg_ready = rdy_q;
    assign cfg_err   = err_q;
    assign locked    = locked_q;
    assign ce        = ce_q;
    assign sq        = sq_q;

endmodule

// File: tb/tb_frac_clken_gen.sv
// Testbench for frac_clken_gen: randomized and directed config traffic,
// with a closed-form reference model feeding a scoreboard queue that a
// negedge monitor drains against the DUT outputs.
`timescale 1ns/1ps
module tb_frac_clken_gen;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 32;
    localparam int SETTLE = 16;
    localparam int CH_W   = 2;
    localparam logic [NUM_CH*ACC_W-1:0] DEF_INC =
        {32'h0000_0000, 32'h2000_0000, 32'h28F5_C28F};

    logic              refclk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic [ACC_W-1:0]  cfg_phase = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] sq;
    logic              locked;

    frac_clken_gen #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .SETTLE(SETTLE), .DEF_INC(DEF_INC)
    ) dut (
        .refclk(refclk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .ce(ce), .sq(sq), .locked(locked)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [NUM_CH-1:0] ce;
        logic [NUM_CH-1:0] sq;
        logic              locked;
        logic              ready;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model: each channel is described by the phase p it was
    // loaded with, its increment, and m = cycles since the load. Position is
    // p + m*inc in wide arithmetic; a pulse occurs whenever the integer part
    // (position / 2^ACC_W) steps, and the square wave is bit ACC_W-1.
    logic [63:0]       m_p[NUM_CH];
    logic [63:0]       m_inc[NUM_CH];
    logic [63:0]       m_m[NUM_CH];
    logic [NUM_CH-1:0] m_ce, m_sq;
    logic              m_ready = 1'b0;
    logic              m_err;
    logic              pend;
    int                pend_ch;
    logic [63:0]       pend_inc, pend_phase;
    int                edge_cnt, unlock_edge;
    int                n_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    endtask

    task automatic tmo(input string nm);
        n_checks++;
        $display("FAIL %s: timed out waiting at %0t", nm, $time);
    endtask

    // Model step on every rising edge, then queue the expected outputs.
    always @(posedge refclk) begin
        exp_t        e;
        logic        take;
        logic [63:0] a, b;
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_p[k]   = 64'd0;
                m_inc[k] = 64'(DEF_INC[k*ACC_W +: ACC_W]);
                m_m[k]   = 64'd0;
            end
            m_ce        = '0;
            m_sq        = '0;
            m_ready     = 1'b0;
            m_err       = 1'b0;
            pend        = 1'b0;
            edge_cnt    = 0;
            unlock_edge = SETTLE;
        end else begin
            take = cfg_valid && m_ready;
            edge_cnt++;
            for (int k = 0; k < NUM_CH; k++) begin
                if (pend && pend_ch == k) begin
                    m_p[k]   = pend_phase;
                    m_inc[k] = pend_inc;
                    m_m[k]   = 64'd0;
                    m_ce[k]  = 1'b0;
                    m_sq[k]  = pend_phase[ACC_W-1];
                end else begin
                    m_m[k]  = m_m[k] + 64'd1;
                    a       = m_p[k] + m_m[k] * m_inc[k];
                    b       = m_p[k] + (m_m[k] - 64'd1) * m_inc[k];
                    m_ce[k] = ((a >> ACC_W) != (b >> ACC_W));
                    m_sq[k] = a[ACC_W-1];
                end
            end
            pend  = 1'b0;
            m_err = 1'b0;
            if (take) begin
                n_acc++;
                if (int'(cfg_ch) < NUM_CH) begin
                    pend        = 1'b1;
                    pend_ch     = int'(cfg_ch);
                    pend_inc    = 64'(cfg_inc);
                    pend_phase  = 64'(cfg_phase);
                    unlock_edge = edge_cnt + 1 + SETTLE;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_ready = (edge_cnt >= unlock_edge);
        end
        e.ce     = m_ce;
        e.sq     = m_sq;
        e.locked = m_ready;
        e.ready  = m_ready;
        e.err    = m_err;
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs to the queued expectation mid-cycle.
    always @(negedge refclk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ce",        32'(ce),        32'(e.ce));
            chk("sq",        32'(sq),        32'(e.sq));
            chk("locked",    32'(locked),    32'(e.locked));
            chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
            chk("cfg_err",   32'(cfg_err),   32'(e.err));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic wait_acc(input int start, input string nm);
        int i;
        for (i = 0; i < 200; i++) begin
            @(posedge refclk);
            #1;
            if (n_acc != start) break;
        end
        if (i == 200) tmo(nm);
    endtask

    task automatic send(input int ch, input logic [31:0] inc, input logic [31:0] ph);
        int start;
        @(posedge refclk);
        #1;
        start     = n_acc;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_inc   = inc;
        cfg_phase = ph;
        wait_acc(start, "accept");
        cfg_valid = 1'b0;
    endtask

    // Count cycles with cfg_ready low following an accept, until it rises.
    task automatic count_ready_low(input string nm);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge refclk);
            if (cfg_ready === 1'b0 && locked === 1'b0) n++;
            else break;
        end
        chk(nm, 32'(n), 32'(SETTLE + 1));
    endtask

    task automatic do_reset();
        @(negedge refclk);
        #1 rst = 1'b0;
        #1;
        chk("rst_ce",     32'(ce),        32'd0);
        chk("rst_sq",     32'(sq),        32'd0);
        chk("rst_locked", 32'(locked),    32'd0);
        chk("rst_ready",  32'(cfg_ready), 32'd0);
        chk("rst_err",    32'(cfg_err),   32'd0);
        wait_cycles(3);
        @(negedge refclk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int start;
        int ch;
        logic [31:0] inc;
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        #1 rst = 1'b1;
        // defaults: ch1 period 8, ch2 idle
        wait_cycles(60);

        // reprogram ch0 with a phase offset
        send(0, 32'h4000_0000, 32'hC000_0000);
        count_ready_low("lock_low_cycles");
        wait_cycles(30);

        // out-of-range channel
        send(3, 32'h1234_5678, 32'h0000_0000);
        wait_cycles(10);

        // back-to-back with cfg_valid held high
        @(posedge refclk);
        #1;
        start     = n_acc;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_inc   = 32'h1000_0000;
        cfg_phase = 32'h0000_0000;
        wait_acc(start, "b2b_first");
        start     = n_acc;
        cfg_ch    = 2'd2;
        cfg_inc   = 32'h0800_0000;
        cfg_phase = 32'h8000_0000;
        count_ready_low("b2b_ready_low");
        wait_acc(start, "b2b_second");
        cfg_valid = 1'b0;
        wait_cycles(40);

        // reset two cycles into settle after an apply
        send(1, 32'h1000_0000, 32'h0000_0000);
        wait_cycles(3);
        do_reset();
        wait_cycles(50);

        // zero and maximum increment
        send(0, 32'h0000_0000, 32'h8000_0000);
        wait_cycles(1000);
        send(2, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_cycles(110);

        // randomized traffic, including invalid channels and early requests
        for (int it = 0; it < 25; it++) begin
            ch = int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       inc = $urandom;
                1:       inc = $urandom >> $urandom_range(1, 12);
                2:       inc = 32'h1 << $urandom_range(24, 31);
                default: inc = 32'hFFFF_FFFF - $urandom_range(0, 255);
            endcase
            send(ch, inc, $urandom);
            wait_cycles(int'($urandom_range(0, 30)));
        end

        wait_cycles(40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
